// File: rtl/seq_pkg.sv
// Shared definitions for the run sequencer.
//   seq_state_t : sequencer FSM states
//   res_t       : one per-program result (index, cycle count, timeout flag)
//   idx_width() : width of a program index (at least 1 bit)
// Default parameter values for run_sequencer live here so that the
// top level and any wrappers stay in agreement.
package seq_pkg;

    localparam int SEQ_NUM_PROGS_DEF = 3;
    localparam int SEQ_ADDR_W_DEF    = 10;
    localparam int SEQ_CNT_W_DEF     = 16;
    localparam int SEQ_TIMEOUT_DEF   = 4096;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [7:0]  idx;
        logic [31:0] cycles;
        logic        timeout;
    } res_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Holds at all-ones instead of wrapping. Clear has priority over enable.
// Ports:
//   clk_i    clock
//   reset_i  synchronous active-high reset (count to 0)
//   clr_i    synchronous clear
//   en_i     count enable
//   count_o  current count
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/run_sequencer.sv
// Run scheduler for the single-cycle core. On a start pulse it launches
// programs 0..NUM_PROGS-1 in turn through the core's req/done handshake,
// presents each program's start address, counts the cycles the core keeps
// done low, and emits one result strobe per program.
//
// Build option: define SEQ_WATCHDOG_EN to abort runs that reach TIMEOUT-1
// counted cycles; otherwise RUN waits indefinitely and res_timeout is 0.
//
// Ports:
//   clk              single clock, rising edge
//   reset            synchronous active-high reset
//   start            one-cycle pulse starting a full sequence (ignored when busy)
//   prog_base        start-address table, entry i at [i*ADDR_W +: ADDR_W]
//   core_done        core idle indication
//   core_req         one-cycle launch pulse to the core
//   core_start_addr  PC load value, valid LAUNCH through REPORT
//   busy             high outside IDLE
//   all_done         sticky, set after the last REPORT, cleared on accepted start
//   res_valid        one-cycle result strobe
//   res_idx          program index of the result
//   res_cycles       measured run cycles (saturating)
//   res_timeout      run was aborted by the watchdog
//
// state  | meaning
// IDLE   | waiting for start
// LAUNCH | core_req pulse, counter cleared
// RUN    | core busy, counting cycles until core_done
// REPORT | result strobe, then next program or back to IDLE
module run_sequencer
    import seq_pkg::*;
#(
    parameter int NUM_PROGS = SEQ_NUM_PROGS_DEF,
    parameter int ADDR_W    = SEQ_ADDR_W_DEF,
    parameter int CNT_W     = SEQ_CNT_W_DEF,
    parameter int TIMEOUT   = SEQ_TIMEOUT_DEF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [NUM_PROGS*ADDR_W-1:0]       prog_base,
    input  logic                              core_done,
    output logic                              core_req,
    output logic [ADDR_W-1:0]                 core_start_addr,
    output logic                              busy,
    output logic                              all_done,
    output logic                              res_valid,
    output logic [idx_width(NUM_PROGS)-1:0]   res_idx,
    output logic [CNT_W-1:0]                  res_cycles,
    output logic                              res_timeout
);

    localparam int IDX_W = idx_width(NUM_PROGS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PROGS - 1);

`ifdef SEQ_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    // If TIMEOUT-1 is beyond the counter range the counter saturates first
    // and the watchdog can never trip; the truncated compare value must not
    // be allowed to alias onto a smaller count.
    localparam bit WD_REACHABLE =
        ((longint'(TIMEOUT) - 1) < (longint'(1) << CNT_W)) && (TIMEOUT >= 1);
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

    seq_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  next_idx;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              all_done_q, all_done_d;
    logic [IDX_W-1:0]  res_idx_q, res_idx_d;
    logic [CNT_W-1:0]  res_cycles_q, res_cycles_d;
    logic              res_timeout_q, res_timeout_d;

    logic              cnt_clr;
    logic              cnt_en;
    logic [CNT_W-1:0]  cnt;
    logic              wd_hit;

    logic [ADDR_W-1:0] base_arr [NUM_PROGS];

    always_comb begin
        for (int i = 0; i < NUM_PROGS; i++) begin
            base_arr[i] = prog_base[i*ADDR_W +: ADDR_W];
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_cnt (
        .clk_i   (clk),
        .reset_i (reset),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .count_o (cnt)
    );

`ifdef SEQ_WATCHDOG_EN
    assign wd_hit = WD_EN && WD_REACHABLE && (cnt == TIMEOUT_M1);
`else
    assign wd_hit = WD_EN && WD_REACHABLE && (cnt == TIMEOUT_M1);
`endif

    assign next_idx = idx_q + IDX_W'(1);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        addr_d        = addr_q;
        all_done_d    = all_done_q;
        res_idx_d     = res_idx_q;
        res_cycles_d  = res_cycles_q;
        res_timeout_d = res_timeout_q;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LAUNCH;
                    idx_d      = '0;
                    addr_d     = base_arr[0];
                    all_done_d = 1'b0;
                end
            end
            LAUNCH: begin
                cnt_clr = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                // core_done wins over a simultaneous watchdog hit.
                if (core_done) begin
                    state_d       = REPORT;
                    res_idx_d     = idx_q;
                    res_cycles_d  = cnt;
                    res_timeout_d = 1'b0;
                end else if (wd_hit) begin
                    state_d       = REPORT;
                    res_idx_d     = idx_q;
                    res_cycles_d  = cnt;
                    res_timeout_d = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            REPORT: begin
                if (idx_q == LAST_IDX) begin
                    state_d    = IDLE;
                    all_done_d = 1'b1;
                end else begin
                    state_d = LAUNCH;
                    idx_d   = next_idx;
                    addr_d  = base_arr[next_idx];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            addr_q        <= '0;
            all_done_q    <= 1'b0;
            res_idx_q     <= '0;
            res_cycles_q  <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            addr_q        <= addr_d;
            all_done_q    <= all_done_d;
            res_idx_q     <= res_idx_d;
            res_cycles_q  <= res_cycles_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    assign core_req        = (state_q == LAUNCH);
    assign busy            = (state_q != IDLE);
    assign res_valid       = (state_q == REPORT);
    assign core_start_addr = addr_q;
    assign all_done        = all_done_q;
    assign res_idx         = res_idx_q;
    assign res_cycles      = res_cycles_q;
    assign res_timeout     = res_timeout_q;

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Top-level run scheduler for the single-cycle core. It launches each of `NUM_PROGS` programs in turn through the core's `req`/`done` handshake, presents the program's start address for the PC load, and measures each run's cycle count. It reports one result per program and sits between the testbench/top-level `start` pulse and the core's `req` input.

## Interface
- `NUM_PROGS`, default 3: number of programs sequenced, index 0 first.
- `ADDR_W`, default 10: PC/instruction-address width.
- `CNT_W`, default 16: cycle-counter width.
- `TIMEOUT`, default 4096: watchdog limit in RUN cycles; only used with `SEQ_WATCHDOG_EN`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse that begins a full sequence; ignored while `busy`.
- `prog_base`  in  NUM_PROGS*ADDR_W  start-address table; entry i is bits [i*ADDR_W +: ADDR_W].
- `core_done`  in  1  core's `done` output (high = core idle).
- `core_req`  out  1  one-cycle launch pulse to the core's `req`.
- `core_start_addr`  out  ADDR_W  PC load value, valid from LAUNCH through REPORT.
- `busy`  out  1  high in every state except IDLE.
- `all_done`  out  1  sticky; set after the last REPORT, cleared when `start` is accepted.
- `res_valid`  out  1  one-cycle result strobe.
- `res_idx`  out  $clog2(NUM_PROGS) (min 1)  program index for the result.
- `res_cycles`  out  CNT_W  measured cycles, saturating.
- `res_timeout`  out  1  run was aborted by the watchdog.

## Operation
- States: IDLE, LAUNCH, RUN, REPORT.
- IDLE: `start`=1 moves to LAUNCH, sets idx to 0 and clears `all_done`.
- LAUNCH: lasts exactly 1 cycle. `core_req`=1, `core_start_addr`=prog_base[idx], counter cleared to 0. Next state is RUN.
- RUN: while `core_done`=0, counter increments by 1 per cycle and saturates at 2^CNT_W−1 (no wrap). The first RUN cycle that samples `core_done`=1 moves to REPORT without incrementing the counter.
- Degenerate run: if `core_done`=1 in the first RUN cycle, the result is `res_cycles`=0.
- REPORT: lasts exactly 1 cycle. `res_valid`=1, `res_idx`=idx, `res_cycles`=counter, `res_timeout` as latched.
  - If idx==NUM_PROGS−1: go to IDLE and set `all_done`.
  - Otherwise: idx+1, go to LAUNCH.
- `start` while `busy` is ignored; there is no restart mid-sequence.
- `core_req` is never high for two consecutive cycles.
- `res_*` hold their last values between strobes; only `res_valid` pulses.

## Timing
- Reset values: state IDLE, idx 0, counter 0, all outputs 0, including `core_start_addr` and `res_*`.
- `reset` overrides everything in the same edge, including mid-RUN. The core is not re-requested; the next `start` relaunches from program 0.
- `start` at edge N leads to LAUNCH (`core_req`=1) in cycle N+1.
- A run that takes K cycles with `core_done` low has REPORT in the cycle after `core_done` is first sampled high, with `res_cycles`=K.
- REPORT-to-next-`core_req` latency is 1 cycle, so inter-program overhead is 2 cycles (REPORT + LAUNCH).
- Sequence latency: sum over programs of (K_i + 3) cycles from `start` to `all_done`.

## Configuration
- `SEQ_WATCHDOG_EN` defined: in RUN, when the counter equals TIMEOUT−1 and `core_done`=0, the next state is REPORT with `res_timeout`=1 and `res_cycles`=TIMEOUT−1.
  - The sequence continues with the next program; its LAUNCH `req` resets the core's PC and re-enables it.
  - `core_done`=1 in the same cycle takes priority: normal result, `res_timeout`=0.
- `SEQ_WATCHDOG_EN` undefined: no timeout logic, `res_timeout` is tied 0, and RUN waits indefinitely.

## Structure
- Package `seq_pkg` holds:
  - `seq_state_t` enum (IDLE, LAUNCH, RUN, REPORT);
  - default parameter constants;
  - the `res_t` struct (idx, cycles, timeout) for the bench scoreboard.
- One sub-module, `sat_counter`: CNT_W-bit counter with synchronous clear and enable, saturating at max. It is reused later for performance counters.

## Test plan
- Program lengths: core model holds `done` low for 5, 12 and 1 cycles.
  - Expect REPORTs with (idx,cycles) = (0,5), (1,12), (2,1).
  - Expect `all_done`=1 after the third REPORT and `core_req` asserted exactly 3 times.
- `prog_base` = {0x000, 0x040, 0x100}: `core_start_addr` equals each entry during the matching LAUNCH and stays stable through REPORT.
- Immediate done: `core_done` held 1 throughout. Each result has cycles=0, and each REPORT→LAUNCH gap is 1 cycle.
- Reset and busy handling:
  - Assert `reset` in the 4th RUN cycle of program 1: next cycle all outputs are 0 and state is IDLE.
  - A `start` pulse while `busy` produces no extra `core_req`.
- Watchdog and saturation:
  - With `SEQ_WATCHDOG_EN`, TIMEOUT=8, program 1 never finishing: result (1,7,timeout=1), and program 2 still launches.
  - With CNT_W=4 and a 20-cycle run (macro off): `res_cycles`=15.
